// File: rtl/parking_pkg.sv
// parking_pkg: phase type, calendar constants and a saturating counter helper
// shared by the parking_ctrl_v2 slice.
package parking_pkg;

  typedef enum logic [1:0] {
    PH_DAY     = 2'd0,
    PH_SHIFT   = 2'd1,
    PH_EVENING = 2'd2
  } phase_t;

  localparam int HOURS_PER_DAY = 24;

  function automatic int unsigned sat_inc(input int unsigned value, input int unsigned limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

endpackage

// File: rtl/parking_capacity_sched.sv
// parking_capacity_sched: registered hour -> phase/capacity schedule with an
// illegal-hour fault flag. Phase and caps freeze while disabled or hour > 23.
module parking_capacity_sched
  import parking_pkg::*;
#(
  parameter int CNT_W         = 10,
  parameter int UNI_CAPACITY  = 500,
  parameter int MISC_CAPACITY = 200,
  parameter int STEP          = 50,
  parameter int DAY_START     = 8,
  parameter int SHIFT_START   = 13,
  parameter int SHIFT_END     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enabled,
  input  logic [4:0]       i_hour,
  output logic [CNT_W-1:0] o_uni_cap,
  output logic [CNT_W-1:0] o_misc_cap,
  output logic             o_hour_fault
);

  localparam int NSTEPS = SHIFT_END - SHIFT_START;

  phase_t     r_phase, w_phase_next;
  logic [4:0] r_steps, w_steps_next;
  logic       r_hour_fault;
  int         w_hour;
  int         w_steps;
  logic       w_hour_legal;

  assign w_hour       = int'({27'd0, i_hour});
  assign w_hour_legal = (w_hour < HOURS_PER_DAY);

  // Hours outside the day and shift windows (either side of midnight) are evening.
  always_comb begin
    w_phase_next = r_phase;
    w_steps_next = r_steps;
    if (i_enabled && w_hour_legal) begin
      if (w_hour >= DAY_START && w_hour < SHIFT_START) begin
        w_phase_next = PH_DAY;
        w_steps_next = '0;
      end else if (w_hour >= SHIFT_START && w_hour < SHIFT_END) begin
        w_phase_next = PH_SHIFT;
        w_steps_next = 5'(w_hour - SHIFT_START + 1);
      end else begin
        w_phase_next = PH_EVENING;
        w_steps_next = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase      <= PH_DAY;
      r_steps      <= '0;
      r_hour_fault <= 1'b0;
    end else begin
      r_phase      <= w_phase_next;
      r_steps      <= w_steps_next;
      r_hour_fault <= i_enabled && !w_hour_legal;
    end
  end

  always_comb begin
    w_steps = 0;
    case (r_phase)
      PH_SHIFT:   w_steps = int'({27'd0, r_steps});
      PH_EVENING: w_steps = NSTEPS;
      default:    w_steps = 0;
    endcase
  end

  assign o_uni_cap    = CNT_W'(UNI_CAPACITY - STEP * w_steps);
  assign o_misc_cap   = CNT_W'(MISC_CAPACITY + STEP * w_steps);
  assign o_hour_fault = r_hour_fault;

endmodule

// File: rtl/parking_ctrl_v2.sv
// parking_ctrl_v2: two-class occupancy tracker with req/ack entry and exit gates.
// Optional statistics (peaks, refusal count) are built when PARKING_STATS_EN is defined.
module parking_ctrl_v2
  import parking_pkg::*;
#(
  parameter int CNT_W         = 10,
  parameter int UNI_CAPACITY  = 500,
  parameter int MISC_CAPACITY = 200,
  parameter int STEP          = 50,
  parameter int DAY_START     = 8,
  parameter int SHIFT_START   = 13,
  parameter int SHIFT_END     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enabled,
  input  logic [4:0]       i_hour,
  input  logic             i_entry_req,
  input  logic             i_entry_is_uni,
  output logic             o_entry_ack,
  output logic             o_entry_grant,
  input  logic             i_exit_req,
  input  logic             i_exit_is_uni,
  output logic             o_exit_ack,
  output logic [CNT_W-1:0] o_uni_parked,
  output logic [CNT_W-1:0] o_misc_parked,
  output logic [CNT_W-1:0] o_uni_space,
  output logic [CNT_W-1:0] o_misc_space,
  output logic             o_uni_has_space,
  output logic             o_misc_has_space,
  output logic             o_over_capacity,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_peak_uni,
  output logic [CNT_W-1:0] o_peak_misc,
  output logic [CNT_W-1:0] o_reject_cnt
);

  if (UNI_CAPACITY + MISC_CAPACITY >= (1 << CNT_W)) begin : g_err_width
    $error("parking_ctrl_v2: UNI_CAPACITY+MISC_CAPACITY does not fit in CNT_W");
  end
  if (STEP * (SHIFT_END - SHIFT_START) > UNI_CAPACITY) begin : g_err_step
    $error("parking_ctrl_v2: STEP*NSTEPS exceeds UNI_CAPACITY");
  end
  if (!(DAY_START < SHIFT_START && SHIFT_START < SHIFT_END && SHIFT_END <= HOURS_PER_DAY)) begin : g_err_hours
    $error("parking_ctrl_v2: hour window ordering is invalid");
  end

  logic [CNT_W-1:0] w_uni_cap, w_misc_cap;
  logic             w_hour_fault;

  parking_capacity_sched #(
    .CNT_W        (CNT_W),
    .UNI_CAPACITY (UNI_CAPACITY),
    .MISC_CAPACITY(MISC_CAPACITY),
    .STEP         (STEP),
    .DAY_START    (DAY_START),
    .SHIFT_START  (SHIFT_START),
    .SHIFT_END    (SHIFT_END)
  ) u_sched (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_enabled   (i_enabled),
    .i_hour      (i_hour),
    .o_uni_cap   (w_uni_cap),
    .o_misc_cap  (w_misc_cap),
    .o_hour_fault(w_hour_fault)
  );

  logic [CNT_W-1:0] r_uni_parked, r_misc_parked;
  logic             r_entry_ack, r_entry_grant, r_exit_ack, r_exit_fault;
  logic             w_entry_acc, w_exit_acc, w_grant, w_exit_empty;
  logic             w_uni_dec, w_misc_dec, w_uni_inc, w_misc_inc;
  logic [CNT_W-1:0] w_uni_after, w_misc_after, w_uni_next, w_misc_next;

  // A request is taken only while its ack is low, giving one transaction per two cycles.
  assign w_entry_acc  = i_enabled && i_entry_req && !r_entry_ack;
  assign w_exit_acc   = i_enabled && i_exit_req && !r_exit_ack;

  assign w_uni_dec    = w_exit_acc && i_exit_is_uni && (r_uni_parked != '0);
  assign w_misc_dec   = w_exit_acc && !i_exit_is_uni && (r_misc_parked != '0);
  assign w_exit_empty = w_exit_acc && (i_exit_is_uni ? (r_uni_parked == '0) : (r_misc_parked == '0));

  // Exit is applied first so a car leaving a full class frees a slot for a same-cycle entry.
  assign w_uni_after  = r_uni_parked - CNT_W'(w_uni_dec);
  assign w_misc_after = r_misc_parked - CNT_W'(w_misc_dec);
  assign w_grant      = i_entry_is_uni ? (w_uni_after < w_uni_cap) : (w_misc_after < w_misc_cap);
  assign w_uni_inc    = w_entry_acc && i_entry_is_uni && w_grant;
  assign w_misc_inc   = w_entry_acc && !i_entry_is_uni && w_grant;
  assign w_uni_next   = w_uni_after + CNT_W'(w_uni_inc);
  assign w_misc_next  = w_misc_after + CNT_W'(w_misc_inc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_uni_parked  <= '0;
      r_misc_parked <= '0;
      r_entry_ack   <= 1'b0;
      r_entry_grant <= 1'b0;
      r_exit_ack    <= 1'b0;
      r_exit_fault  <= 1'b0;
    end else begin
      r_uni_parked  <= w_uni_next;
      r_misc_parked <= w_misc_next;
      r_entry_ack   <= w_entry_acc;
      r_entry_grant <= w_entry_acc && w_grant;
      r_exit_ack    <= w_exit_acc;
      r_exit_fault  <= w_exit_empty;
    end
  end

  assign o_entry_ack      = r_entry_ack;
  assign o_entry_grant    = r_entry_grant;
  assign o_exit_ack       = r_exit_ack;
  assign o_uni_parked     = r_uni_parked;
  assign o_misc_parked    = r_misc_parked;
  assign o_uni_space      = (r_uni_parked < w_uni_cap) ? (w_uni_cap - r_uni_parked) : '0;
  assign o_misc_space     = (r_misc_parked < w_misc_cap) ? (w_misc_cap - r_misc_parked) : '0;
  assign o_uni_has_space  = (o_uni_space != '0);
  assign o_misc_has_space = (o_misc_space != '0);
  assign o_over_capacity  = (r_uni_parked > w_uni_cap) || (r_misc_parked > w_misc_cap);
  assign o_fault          = r_exit_fault || w_hour_fault;

`ifdef PARKING_STATS_EN
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] r_peak_uni, r_peak_misc, r_reject_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_peak_uni   <= '0;
      r_peak_misc  <= '0;
      r_reject_cnt <= '0;
    end else begin
      if (w_uni_next > r_peak_uni)   r_peak_uni  <= w_uni_next;
      if (w_misc_next > r_peak_misc) r_peak_misc <= w_misc_next;
      if (w_entry_acc && !w_grant)
        r_reject_cnt <= CNT_W'(sat_inc(32'(r_reject_cnt), CNT_MAX));
    end
  end

  assign o_peak_uni   = r_peak_uni;
  assign o_peak_misc  = r_peak_misc;
  assign o_reject_cnt = r_reject_cnt;
`else
  assign o_peak_uni   = '0;
  assign o_peak_misc  = '0;
  assign o_reject_cnt = '0;
`endif

endmodule

// File: tb/tb_parking_ctrl_v2.sv
// tb_parking_ctrl_v2: vector table, directed corner sequences and randomized
// traffic checked against an integer-level occupancy model.
module tb_parking_ctrl_v2;

  localparam int CNT_W         = 10;
  localparam int UNI_CAPACITY  = 500;
  localparam int MISC_CAPACITY = 200;
  localparam int STEP          = 50;
  localparam int DAY_START     = 8;
  localparam int SHIFT_START   = 13;
  localparam int SHIFT_END     = 16;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             enabled = 1'b0;
  logic [4:0]       hour = 5'd8;
  logic             entryReq = 1'b0, entryIsUni = 1'b0, exitReq = 1'b0, exitIsUni = 1'b0;
  logic             entryAck, entryGrant, exitAck, uniHas, miscHas, overCap, fault;
  logic [CNT_W-1:0] uniParked, miscParked, uniSpace, miscSpace, peakUni, peakMisc, rejectCnt;

  int nChecks = 0;
  int nFails  = 0;

  int mUni, mMisc, mUniCap, mMiscCap, mReject, mPeakUni, mPeakMisc;
  bit mEntryAck, mGrant, mExitAck, mFault;

  always #5 clk = ~clk;

  parking_ctrl_v2 dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_enabled       (enabled),
    .i_hour          (hour),
    .i_entry_req     (entryReq),
    .i_entry_is_uni  (entryIsUni),
    .o_entry_ack     (entryAck),
    .o_entry_grant   (entryGrant),
    .i_exit_req      (exitReq),
    .i_exit_is_uni   (exitIsUni),
    .o_exit_ack      (exitAck),
    .o_uni_parked    (uniParked),
    .o_misc_parked   (miscParked),
    .o_uni_space     (uniSpace),
    .o_misc_space    (miscSpace),
    .o_uni_has_space (uniHas),
    .o_misc_has_space(miscHas),
    .o_over_capacity (overCap),
    .o_fault         (fault),
    .o_peak_uni      (peakUni),
    .o_peak_misc     (peakMisc),
    .o_reject_cnt    (rejectCnt)
  );

  typedef struct {
    bit en; int hr; bit eReq; bit eUni; bit xReq; bit xUni;
    int expUni; int expMisc; bit expEAck; bit expGrant; bit expXAck;
    int expUniSpace; int expMiscSpace;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input int h, input bit eReq, input bit eUni,
                               input bit xReq, input bit xUni);
    enabled    = en;
    hour       = 5'(h);
    entryReq   = eReq;
    entryIsUni = eUni;
    exitReq    = xReq;
    exitIsUni  = xUni;
  endtask

  function automatic void capsFor(input int h, output int u, output int m);
    int steps;
    if (h >= DAY_START && h < SHIFT_START)        steps = 0;
    else if (h >= SHIFT_START && h < SHIFT_END)   steps = h - SHIFT_START + 1;
    else                                          steps = SHIFT_END - SHIFT_START;
    u = UNI_CAPACITY - STEP * steps;
    m = MISC_CAPACITY + STEP * steps;
  endfunction

  function automatic int spaceOf(input int cap, input int parked);
    return (parked < cap) ? cap - parked : 0;
  endfunction

  task automatic modelReset();
    mUni = 0; mMisc = 0; mReject = 0; mPeakUni = 0; mPeakMisc = 0;
    mUniCap = UNI_CAPACITY; mMiscCap = MISC_CAPACITY;
    mEntryAck = 0; mGrant = 0; mExitAck = 0; mFault = 0;
  endtask

  task automatic modelStep();
    bit eAcc, xAcc, grantNow, faultNow;
    int uniAfter, miscAfter, h;
    h         = int'(hour);
    eAcc      = enabled && entryReq && !mEntryAck;
    xAcc      = enabled && exitReq && !mExitAck;
    grantNow  = 0;
    faultNow  = 0;
    uniAfter  = mUni;
    miscAfter = mMisc;
    if (xAcc) begin
      if (exitIsUni) begin
        if (mUni == 0) faultNow = 1; else uniAfter = mUni - 1;
      end else begin
        if (mMisc == 0) faultNow = 1; else miscAfter = mMisc - 1;
      end
    end
    if (eAcc) begin
      if (entryIsUni) begin
        grantNow = (uniAfter < mUniCap);
        if (grantNow) uniAfter++;
      end else begin
        grantNow = (miscAfter < mMiscCap);
        if (grantNow) miscAfter++;
      end
      if (!grantNow && mReject < CNT_MAX) mReject++;
    end
    if (enabled && h >= 24) faultNow = 1;
    if (enabled && h < 24) capsFor(h, mUniCap, mMiscCap);
    mUni  = uniAfter;
    mMisc = miscAfter;
    if (mUni > mPeakUni)   mPeakUni = mUni;
    if (mMisc > mPeakMisc) mPeakMisc = mMisc;
    mEntryAck = eAcc;
    mGrant    = grantNow;
    mExitAck  = xAcc;
    mFault    = faultNow;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_entry_ack"},  int'(entryAck),   int'(mEntryAck));
    checkOutput({tag, "_grant"},      int'(entryGrant), int'(mGrant));
    checkOutput({tag, "_exit_ack"},   int'(exitAck),    int'(mExitAck));
    checkOutput({tag, "_uni_parked"}, int'(uniParked),  mUni);
    checkOutput({tag, "_misc_parked"},int'(miscParked), mMisc);
    checkOutput({tag, "_uni_space"},  int'(uniSpace),   spaceOf(mUniCap, mUni));
    checkOutput({tag, "_misc_space"}, int'(miscSpace),  spaceOf(mMiscCap, mMisc));
    checkOutput({tag, "_uni_has"},    int'(uniHas),     int'(spaceOf(mUniCap, mUni) != 0));
    checkOutput({tag, "_misc_has"},   int'(miscHas),    int'(spaceOf(mMiscCap, mMisc) != 0));
    checkOutput({tag, "_over_cap"},   int'(overCap),    int'(mUni > mUniCap || mMisc > mMiscCap));
    checkOutput({tag, "_fault"},      int'(fault),      int'(mFault));
`ifdef PARKING_STATS_EN
    checkOutput({tag, "_peak_uni"},   int'(peakUni),    mPeakUni);
    checkOutput({tag, "_peak_misc"},  int'(peakMisc),   mPeakMisc);
    checkOutput({tag, "_reject_cnt"}, int'(rejectCnt),  mReject);
`else
    checkOutput({tag, "_peak_uni"},   int'(peakUni),    0);
    checkOutput({tag, "_peak_misc"},  int'(peakMisc),   0);
    checkOutput({tag, "_reject_cnt"}, int'(rejectCnt),  0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   curHour;

    vecs[0]  = '{1, 8, 1, 1, 0, 0,  1, 0, 1, 1, 0,  499, 200};
    vecs[1]  = '{1, 8, 1, 1, 0, 0,  1, 0, 0, 0, 0,  499, 200};
    vecs[2]  = '{1, 8, 1, 1, 0, 0,  2, 0, 1, 1, 0,  498, 200};
    vecs[3]  = '{1, 8, 1, 0, 0, 0,  2, 0, 0, 0, 0,  498, 200};
    vecs[4]  = '{1, 8, 1, 0, 0, 0,  2, 1, 1, 1, 0,  498, 199};
    vecs[5]  = '{1, 8, 0, 0, 1, 1,  1, 1, 0, 0, 1,  499, 199};
    vecs[6]  = '{1, 8, 0, 0, 0, 0,  1, 1, 0, 0, 0,  499, 199};
    vecs[7]  = '{1, 8, 1, 1, 1, 0,  2, 0, 1, 1, 1,  498, 200};
    vecs[8]  = '{1, 8, 0, 0, 0, 0,  2, 0, 0, 0, 0,  498, 200};
    vecs[9]  = '{1, 8, 1, 1, 0, 0,  3, 0, 1, 1, 0,  497, 200};
    vecs[10] = '{1, 8, 0, 0, 0, 0,  3, 0, 0, 0, 0,  497, 200};

    // Reset state
    modelReset();
    applyStimulus(0, 8, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_uni_parked", int'(uniParked), 0);
    checkOutput("rst_misc_parked", int'(miscParked), 0);
    checkOutput("rst_uni_space", int'(uniSpace), 500);
    checkOutput("rst_misc_space", int'(miscSpace), 200);
    checkOutput("rst_entry_ack", int'(entryAck), 0);
    checkOutput("rst_fault", int'(fault), 0);
    checkOutput("rst_reject_cnt", int'(rejectCnt), 0);
    rstN = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].en, vecs[i].hr, vecs[i].eReq, vecs[i].eUni, vecs[i].xReq, vecs[i].xUni);
      tick();
      checkOutput($sformatf("vec%0d_uni_parked", i), int'(uniParked), vecs[i].expUni);
      checkOutput($sformatf("vec%0d_misc_parked", i), int'(miscParked), vecs[i].expMisc);
      checkOutput($sformatf("vec%0d_entry_ack", i), int'(entryAck), int'(vecs[i].expEAck));
      checkOutput($sformatf("vec%0d_grant", i), int'(entryGrant), int'(vecs[i].expGrant));
      checkOutput($sformatf("vec%0d_exit_ack", i), int'(exitAck), int'(vecs[i].expXAck));
      checkOutput($sformatf("vec%0d_uni_space", i), int'(uniSpace), vecs[i].expUniSpace);
      checkOutput($sformatf("vec%0d_misc_space", i), int'(miscSpace), vecs[i].expMiscSpace);
    end

    // Capacity migration, visible one cycle after each hour change (uni_parked = 3)
    applyStimulus(1, 13, 0, 0, 0, 0);
    #1;
    checkOutput("h13_before_edge_uni_space", int'(uniSpace), 497);
    tick();
    checkOutput("h13_uni_space", int'(uniSpace), 447);
    checkOutput("h13_misc_space", int'(miscSpace), 250);
    applyStimulus(1, 14, 0, 0, 0, 0);
    tick();
    checkOutput("h14_uni_space", int'(uniSpace), 397);
    checkOutput("h14_misc_space", int'(miscSpace), 300);
    applyStimulus(1, 15, 0, 0, 0, 0);
    tick();
    checkOutput("h15_uni_space", int'(uniSpace), 347);
    checkOutput("h15_misc_space", int'(miscSpace), 350);

    // Fill uni to 450 at hour 12, then shrink below occupancy
    applyStimulus(1, 12, 0, 0, 0, 0);
    tick();
    checkOutput("h12_uni_space", int'(uniSpace), 497);
    applyStimulus(1, 12, 1, 1, 0, 0);
    for (int i = 0; i < 2000 && mUni < 450; i++) tick();
    applyStimulus(1, 15, 0, 0, 0, 0);
    tick();
    checkOutput("fill_uni_parked", int'(uniParked), 450);
    checkOutput("shrink_over_capacity", int'(overCap), 1);
    checkOutput("shrink_uni_space", int'(uniSpace), 0);
    checkOutput("shrink_uni_has_space", int'(uniHas), 0);
    applyStimulus(1, 15, 1, 1, 0, 0);
    tick();
    checkOutput("over_entry_ack", int'(entryAck), 1);
    checkOutput("over_entry_grant", int'(entryGrant), 0);
    checkOutput("over_uni_parked", int'(uniParked), 450);
`ifdef PARKING_STATS_EN
    checkOutput("over_reject_cnt", int'(rejectCnt), 1);
    checkOutput("over_peak_uni", int'(peakUni), 450);
`else
    checkOutput("over_reject_cnt", int'(rejectCnt), 0);
`endif
    checkModel("over");

    // Misc full, then simultaneous misc exit + entry
    applyStimulus(1, 8, 0, 0, 0, 0);
    tick();
    checkOutput("day_over_capacity", int'(overCap), 0);
    checkOutput("day_uni_space", int'(uniSpace), 50);
    applyStimulus(1, 8, 1, 0, 0, 0);
    for (int i = 0; i < 1000 && mMisc < 200; i++) tick();
    applyStimulus(1, 8, 0, 0, 0, 0);
    tick();
    checkOutput("full_misc_parked", int'(miscParked), 200);
    checkOutput("full_misc_has_space", int'(miscHas), 0);
    applyStimulus(1, 8, 1, 0, 0, 0);
    tick();
    checkOutput("full_entry_ack", int'(entryAck), 1);
    checkOutput("full_entry_grant", int'(entryGrant), 0);
    applyStimulus(1, 8, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 8, 1, 0, 1, 0);
    tick();
    checkOutput("swap_entry_ack", int'(entryAck), 1);
    checkOutput("swap_exit_ack", int'(exitAck), 1);
    checkOutput("swap_grant", int'(entryGrant), 1);
    checkOutput("swap_misc_parked", int'(miscParked), 200);
    checkModel("swap");

    // Exit from empty class and illegal hour faults
    rstN = 1'b0;
    modelReset();
    applyStimulus(1, 8, 0, 0, 0, 0);
    #2;
    rstN = 1'b1;
    applyStimulus(1, 8, 0, 0, 1, 1);
    tick();
    checkOutput("empty_exit_ack", int'(exitAck), 1);
    checkOutput("empty_exit_fault", int'(fault), 1);
    checkOutput("empty_uni_parked", int'(uniParked), 0);
    applyStimulus(1, 14, 0, 0, 0, 0);
    tick();
    checkOutput("empty_fault_cleared", int'(fault), 0);
    applyStimulus(1, 25, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("h25_fault_c%0d", i), int'(fault), 1);
      checkOutput($sformatf("h25_uni_space_c%0d", i), int'(uniSpace), 400);
      checkOutput($sformatf("h25_misc_space_c%0d", i), int'(miscSpace), 300);
    end
    applyStimulus(1, 14, 0, 0, 0, 0);
    tick();
    checkOutput("h25_fault_cleared", int'(fault), 0);

    // Disabled: held request is not accepted and caps freeze
    applyStimulus(0, 20, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("dis_entry_ack_c%0d", i), int'(entryAck), 0);
      checkOutput($sformatf("dis_uni_space_c%0d", i), int'(uniSpace), 400);
    end
    applyStimulus(1, 20, 1, 1, 0, 0);
    tick();
    checkOutput("reen_entry_ack", int'(entryAck), 1);
    checkOutput("reen_grant", int'(entryGrant), 1);
    checkOutput("reen_uni_space", int'(uniSpace), 349);

    // Reset asserted while an ack is high
    applyStimulus(1, 20, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 20, 1, 1, 0, 0);
    tick();
    checkOutput("midack_ack_before", int'(entryAck), 1);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midack_entry_ack", int'(entryAck), 0);
    checkOutput("midack_grant", int'(entryGrant), 0);
    checkOutput("midack_uni_parked", int'(uniParked), 0);
    checkOutput("midack_misc_parked", int'(miscParked), 0);
    checkOutput("midack_fault", int'(fault), 0);
    modelReset();
    applyStimulus(1, 8, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Randomized traffic against the model
    curHour = 8;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) curHour = $urandom_range(0, 25);
      applyStimulus($urandom_range(0, 9) != 0, curHour,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 1) != 0);
      tick();
      checkModel($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
